// File: rtl/sakebi_eth_pkg.sv
// Shared definitions for the sakebi Ethernet receive/transmit path.
// Holds the IEEE 802.3 CRC-32 constants, the default frame length
// limits and the state type of the receive frame delimiter.
package sakebi_eth_pkg;

  // Reflected CRC-32 polynomial, seed, and the register value left
  // after a frame whose FCS is correct has been run through the CRC
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  // Frame length limits in bytes, FCS included
  localparam int ETH_MIN_LEN = 64;
  localparam int ETH_MAX_LEN = 1522;

  // Depth of the delay line that hides the four FCS bytes plus the
  // last payload byte until the frame end is known
  localparam int DL_DEPTH = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/sakebi_crc32_byte.sv
// One-byte step of the reflected Ethernet CRC-32 (LSB first).
// Purely combinational so it can be shared by the RX checker and the
// TX FCS generator.
// Ports:
//   crc_i  : current CRC register value
//   data_i : byte to fold in
//   crc_o  : CRC register value after the byte
module sakebi_crc32_byte
  import sakebi_eth_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] c;

  always_comb begin
    c = crc_i ^ {24'h0, data_i};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    crc_o = c;
  end

endmodule

// File: rtl/sakebi_eth_rx_frame.sv
// Ethernet receive frame delimiter and FCS checker.
// Takes the TLAST-less byte stream from sakebi_rmii_rx, ends a frame
// after IDLE_TIMEOUT cycles without a beat, checks the CRC-32 and the
// length, strips the FCS and re-emits the payload as AXI-Stream with
// TLAST on the last payload byte and TUSER=1 on a bad frame.
// Ports:
//   i_axis_ACLK / i_axis_ARESETn : clock, async active-low reset
//   i_s_axis_TVALID/TDATA        : raw input bytes (TREADY tied high)
//   o_m_axis_TVALID/TDATA/TLAST/TUSER, i_m_axis_TREADY : payload out
//   o_frame_good / o_frame_bad   : frame status pulse with the TLAST load
//   o_overflow                   : pulse when a payload byte is dropped
module sakebi_eth_rx_frame
  import sakebi_eth_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int IDLE_TIMEOUT = 32,
  parameter int MIN_LEN      = ETH_MIN_LEN,
  parameter int MAX_LEN      = ETH_MAX_LEN
) (
  input  logic                  i_axis_ACLK,
  input  logic                  i_axis_ARESETn,
  input  logic                  i_s_axis_TVALID,
  output logic                  o_s_axis_TREADY,
  input  logic [DATA_WIDTH-1:0] i_s_axis_TDATA,
  output logic                  o_m_axis_TVALID,
  input  logic                  i_m_axis_TREADY,
  output logic [DATA_WIDTH-1:0] o_m_axis_TDATA,
  output logic                  o_m_axis_TLAST,
  output logic                  o_m_axis_TUSER,
  output logic                  o_frame_good,
  output logic                  o_frame_bad,
  output logic                  o_overflow
);

  localparam logic [7:0] IDLE_LAST = 8'(IDLE_TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] dl_q [DL_DEPTH];
  logic [DATA_WIDTH-1:0] dl_d [DL_DEPTH];
  logic [15:0]           len_q, len_d;
  logic [31:0]           crc_q, crc_d;
  logic [7:0]            idle_q, idle_d;
  logic                  err_q, err_d;
  logic                  active_q, active_d;
  logic                  pend_q, pend_d;
  logic [DATA_WIDTH-1:0] pendData_q, pendData_d;
  logic                  pendUser_q, pendUser_d;
  logic                  outValid_q, outValid_d;
  logic [DATA_WIDTH-1:0] outData_q, outData_d;
  logic                  outLast_q, outLast_d;
  logic                  outUser_q, outUser_d;
  logic                  good_q, good_d;
  logic                  bad_q, bad_d;
  logic                  ovf_q, ovf_d;

  logic [31:0] crcIn, crcNext;
  logic        outFree, frameErr;

  // The first beat of a frame (active_q low) reseeds the CRC
  assign crcIn = active_q ? crc_q : CRC_INIT;

  sakebi_crc32_byte u_crc (
    .crc_i  (crcIn),
    .data_i (i_s_axis_TDATA),
    .crc_o  (crcNext)
  );

  // The output register can take a new byte if empty or being accepted now
  assign outFree  = !outValid_q || i_m_axis_TREADY;
  assign frameErr = (crc_q != CRC_RESIDUE) || (len_q < 16'(MIN_LEN)) ||
                    (len_q > 16'(MAX_LEN)) || err_q;

  // active_q means the delay line holds a frame in progress. In FLUSH it
  // goes high when the next frame starts while the TLAST beat is still
  // waiting, so that frame keeps accumulating and FLUSH exits to RECV.
  // The finished frame's last byte and status are captured in pend_*
  // because the delay line may be reused before the TLAST beat is loaded.
  always_comb begin
    state_d    = state_q;
    dl_d       = dl_q;
    len_d      = len_q;
    crc_d      = crc_q;
    idle_d     = idle_q;
    err_d      = err_q;
    active_d   = active_q;
    pend_d     = pend_q;
    pendData_d = pendData_q;
    pendUser_d = pendUser_q;
    outValid_d = outValid_q;
    outData_d  = outData_q;
    outLast_d  = outLast_q;
    outUser_d  = outUser_q;
    good_d     = 1'b0;
    bad_d      = 1'b0;
    ovf_d      = 1'b0;

    if (outValid_q && i_m_axis_TREADY) begin
      outValid_d = 1'b0;
      outLast_d  = 1'b0;
      outUser_d  = 1'b0;
    end

    if (i_s_axis_TVALID) begin
      idle_d = '0;
      crc_d  = crcNext;
      if (!active_q) begin
        for (int k = 1; k < DL_DEPTH; k++) dl_d[k] = '0;
        dl_d[0]  = i_s_axis_TDATA;
        len_d    = 16'd1;
        err_d    = 1'b0;
        active_d = 1'b1;
        if (state_q == IDLE) state_d = RECV;
      end else begin
        for (int k = DL_DEPTH - 1; k > 0; k--) dl_d[k] = dl_q[k-1];
        dl_d[0] = i_s_axis_TDATA;
        len_d   = (&len_q) ? len_q : len_q + 16'd1;
        // Sixth and later bytes push the oldest entry out as payload
        if (len_q >= 16'(DL_DEPTH)) begin
          if (outFree && !pend_q) begin
            outValid_d = 1'b1;
            outData_d  = dl_q[DL_DEPTH-1];
            outLast_d  = 1'b0;
            outUser_d  = 1'b0;
          end else begin
            ovf_d = 1'b1;
            err_d = 1'b1;
          end
        end
      end
    end else if (active_q) begin
      // Saturates one short of the timeout so a frame started during a
      // long FLUSH still ends on its first idle cycle back in RECV
      if (idle_q != IDLE_LAST) idle_d = idle_q + 8'd1;
      if (state_q == RECV && idle_q == IDLE_LAST) begin
        active_d = 1'b0;
        if (len_q >= 16'(DL_DEPTH)) begin
          pend_d     = 1'b1;
          pendData_d = dl_q[DL_DEPTH-1];
          pendUser_d = frameErr;
          state_d    = FLUSH;
        end else begin
          bad_d   = 1'b1;
          state_d = IDLE;
        end
      end
    end

    // FLUSH loads the TLAST beat as soon as the output register frees,
    // then waits for it to be accepted
    if (state_q == FLUSH) begin
      if (pend_q) begin
        if (outFree) begin
          outValid_d = 1'b1;
          outData_d  = pendData_q;
          outLast_d  = 1'b1;
          outUser_d  = pendUser_q;
          good_d     = !pendUser_q;
          bad_d      = pendUser_q;
          pend_d     = 1'b0;
        end
      end else if (outValid_q && i_m_axis_TREADY) begin
        state_d = active_d ? RECV : IDLE;
      end
    end
  end

  always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
    if (!i_axis_ARESETn) begin
      state_q    <= IDLE;
      for (int k = 0; k < DL_DEPTH; k++) dl_q[k] <= '0;
      len_q      <= '0;
      crc_q      <= '0;
      idle_q     <= '0;
      err_q      <= 1'b0;
      active_q   <= 1'b0;
      pend_q     <= 1'b0;
      pendData_q <= '0;
      pendUser_q <= 1'b0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outLast_q  <= 1'b0;
      outUser_q  <= 1'b0;
      good_q     <= 1'b0;
      bad_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dl_q       <= dl_d;
      len_q      <= len_d;
      crc_q      <= crc_d;
      idle_q     <= idle_d;
      err_q      <= err_d;
      active_q   <= active_d;
      pend_q     <= pend_d;
      pendData_q <= pendData_d;
      pendUser_q <= pendUser_d;
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      outLast_q  <= outLast_d;
      outUser_q  <= outUser_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      ovf_q      <= ovf_d;
    end
  end

  assign o_s_axis_TREADY = 1'b1;
  assign o_m_axis_TVALID = outValid_q;
  assign o_m_axis_TDATA  = outData_q;
  assign o_m_axis_TLAST  = outLast_q;
  assign o_m_axis_TUSER  = outUser_q;
  assign o_frame_good    = good_q;
  assign o_frame_bad     = bad_q;
  assign o_overflow      = ovf_q;

endmodule

// File: tb/tb_sakebi_eth_rx_frame.sv
// Self-checking bench for sakebi_eth_rx_frame. Frames are built with a
// freshly computed FCS; the expected payload and status come from a
// frame-level model (payload = all but the last 4 bytes, good when the
// trailing 4 bytes equal the CRC-32 of the rest and the length is legal).
module tb_sakebi_eth_rx_frame;

  localparam int TO   = 32;
  localparam int MINL = 64;
  localparam int MAXL = 1522;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       sValid = 1'b0;
  logic       sReady;
  logic [7:0] sData = 8'h00;
  logic       mValid;
  logic       mReady = 1'b1;
  logic [7:0] mData;
  logic       mLast, mUser;
  logic       frameGood, frameBad, overflow;

  int nChecks = 0;
  int nFail   = 0;
  int goodCnt = 0, badCnt = 0, ovfCnt = 0, expGood = 0, expBad = 0;
  logic [7:0] txQ[$];
  logic [9:0] outQ[$];
  logic [9:0] expQ[$];

  always #5 clk = ~clk;

  sakebi_eth_rx_frame #(
    .DATA_WIDTH(8), .IDLE_TIMEOUT(TO), .MIN_LEN(MINL), .MAX_LEN(MAXL)
  ) dut (
    .i_axis_ACLK     (clk),
    .i_axis_ARESETn  (rstN),
    .i_s_axis_TVALID (sValid),
    .o_s_axis_TREADY (sReady),
    .i_s_axis_TDATA  (sData),
    .o_m_axis_TVALID (mValid),
    .i_m_axis_TREADY (mReady),
    .o_m_axis_TDATA  (mData),
    .o_m_axis_TLAST  (mLast),
    .o_m_axis_TUSER  (mUser),
    .o_frame_good    (frameGood),
    .o_frame_bad     (frameBad),
    .o_overflow      (overflow)
  );

  // Collect accepted output beats and status pulses away from the edge
  always @(negedge clk) begin
    #1;
    if (rstN) begin
      if (mValid && mReady) outQ.push_back({mUser, mLast, mData});
      if (frameGood) goodCnt++;
      if (frameBad)  badCnt++;
      if (overflow)  ovfCnt++;
    end
  end

  function automatic logic [31:0] crc_of(input logic [7:0] f[$], input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, f[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build_frame(input int n, input bit counting, input bit corrupt);
    logic [31:0] fcs;
    int pos;
    txQ.delete();
    for (int i = 0; i < n - 4; i++) txQ.push_back(counting ? 8'(i) : 8'($urandom));
    fcs = crc_of(txQ, n - 4);
    for (int k = 0; k < 4; k++) txQ.push_back(fcs[8*k +: 8]);
    if (corrupt) begin
      pos = $urandom_range(0, n - 1);
      txQ[pos] = txQ[pos] ^ 8'(1 << $urandom_range(0, 7));
    end
  endtask

  // Frame-level expectation for txQ[lo .. lo+n-1]
  task automatic model_frame(input int lo, input int n);
    logic [7:0] f[$];
    logic [31:0] fcs;
    bit ok;
    f = txQ[lo : lo + n - 1];
    if (n <= 4) begin
      expBad++;
    end else begin
      fcs = crc_of(f, n - 4);
      ok = (n >= MINL) && (n <= MAXL) && ({f[n-1], f[n-2], f[n-3], f[n-4]} == fcs);
      for (int i = 0; i < n - 4; i++)
        expQ.push_back({(!ok && (i == n - 5)), (i == n - 5), f[i]});
      if (ok) expGood++; else expBad++;
    end
  endtask

  task automatic clear_obs();
    outQ.delete();
    expQ.delete();
    goodCnt = 0; badCnt = 0; ovfCnt = 0; expGood = 0; expBad = 0;
  endtask

  task automatic send_bytes(input int lo, input int n, input int spacing);
    for (int i = lo; i < lo + n; i++) begin
      @(negedge clk); sValid = 1'b1; sData = txQ[i];
      if (spacing > 1) begin
        @(negedge clk); sValid = 1'b0;
        repeat (spacing - 2) @(negedge clk);
      end
    end
    @(negedge clk); sValid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    nChecks++;
    if ({mValid, mData, mLast, mUser, frameGood, frameBad, overflow, sReady} !== {14'h0, 1'b1}) begin
      nFail++;
      $display("[TB] FAIL reset outputs: got %h required %h",
               {mValid, mData, mLast, mUser, frameGood, frameBad, overflow, sReady}, {14'h0, 1'b1});
    end
    @(negedge clk); rstN = 1'b1;
  endtask

  task automatic test_fcs();
    for (int corrupt = 0; corrupt < 2; corrupt++) begin
      build_frame(64, 1'b1, 1'b0);
      if (corrupt == 1) txQ[63] = txQ[63] ^ 8'h01;
      clear_obs();
      model_frame(0, 64);
      send_bytes(0, 64, 8);
      repeat (TO + 20) @(negedge clk);
      nChecks++;
      if (outQ.size() !== expQ.size()) begin
        nFail++; $display("[TB] FAIL fcs%0d beats: got %0d required %0d", corrupt, outQ.size(), expQ.size());
      end
      for (int i = 0; i < outQ.size() && i < expQ.size(); i++) begin
        nChecks++;
        if (outQ[i] !== expQ[i]) begin
          nFail++; $display("[TB] FAIL fcs%0d beat %0d: got %h required %h", corrupt, i, outQ[i], expQ[i]);
        end
      end
      nChecks += 3;
      if (goodCnt !== expGood) begin nFail++; $display("[TB] FAIL fcs%0d good: got %0d required %0d", corrupt, goodCnt, expGood); end
      if (badCnt !== expBad)   begin nFail++; $display("[TB] FAIL fcs%0d bad: got %0d required %0d", corrupt, badCnt, expBad); end
      if (ovfCnt !== 0)        begin nFail++; $display("[TB] FAIL fcs%0d ovf: got %0d required 0", corrupt, ovfCnt); end
    end
  endtask

  task automatic test_runt();
    for (int k = 0; k < 2; k++) begin
      int n;
      n = (k == 0) ? 3 : 5;
      txQ.delete();
      for (int i = 0; i < n; i++) txQ.push_back(8'($urandom));
      clear_obs();
      model_frame(0, n);
      send_bytes(0, n, 1);
      repeat (TO + 20) @(negedge clk);
      nChecks++;
      if (outQ.size() !== expQ.size()) begin
        nFail++; $display("[TB] FAIL runt%0d beats: got %0d required %0d", n, outQ.size(), expQ.size());
      end
      for (int i = 0; i < outQ.size() && i < expQ.size(); i++) begin
        nChecks++;
        if (outQ[i] !== expQ[i]) begin
          nFail++; $display("[TB] FAIL runt%0d beat %0d: got %h required %h", n, i, outQ[i], expQ[i]);
        end
      end
      nChecks += 2;
      if (goodCnt !== expGood) begin nFail++; $display("[TB] FAIL runt%0d good: got %0d required %0d", n, goodCnt, expGood); end
      if (badCnt !== expBad)   begin nFail++; $display("[TB] FAIL runt%0d bad: got %0d required %0d", n, badCnt, expBad); end
    end
  endtask

  task automatic test_idle_gap();
    for (int gap = TO - 1; gap <= TO; gap++) begin
      build_frame(64, 1'b0, 1'b0);
      clear_obs();
      if (gap < TO) model_frame(0, 64);
      else begin model_frame(0, 30); model_frame(30, 34); end
      send_bytes(0, 30, 1);
      repeat (gap - 1) @(negedge clk);
      send_bytes(30, 34, 1);
      repeat (TO + 20) @(negedge clk);
      nChecks++;
      if (outQ.size() !== expQ.size()) begin
        nFail++; $display("[TB] FAIL gap%0d beats: got %0d required %0d", gap, outQ.size(), expQ.size());
      end
      for (int i = 0; i < outQ.size() && i < expQ.size(); i++) begin
        nChecks++;
        if (outQ[i] !== expQ[i]) begin
          nFail++; $display("[TB] FAIL gap%0d beat %0d: got %h required %h", gap, i, outQ[i], expQ[i]);
        end
      end
      nChecks += 2;
      if (goodCnt !== expGood) begin nFail++; $display("[TB] FAIL gap%0d good: got %0d required %0d", gap, goodCnt, expGood); end
      if (badCnt !== expBad)   begin nFail++; $display("[TB] FAIL gap%0d bad: got %0d required %0d", gap, badCnt, expBad); end
    end
  endtask

  // Length boundaries with a valid FCS, then random lengths/corruption
  task automatic test_random_frames();
    int lens[8] = '{MINL - 1, MINL, MAXL, MAXL + 1, 0, 0, 0, 0};
    for (int f = 0; f < 8; f++) begin
      int n;
      bit corrupt;
      n = (f < 4) ? lens[f] : int'($urandom_range(6, 120));
      corrupt = (f >= 4) && ($urandom_range(0, 2) == 0);
      build_frame(n, 1'b0, corrupt);
      clear_obs();
      model_frame(0, n);
      send_bytes(0, n, int'($urandom_range(1, 3)));
      repeat (TO + 20) @(negedge clk);
      nChecks++;
      if (outQ.size() !== expQ.size()) begin
        nFail++; $display("[TB] FAIL rand%0d len %0d beats: got %0d required %0d", f, n, outQ.size(), expQ.size());
      end
      for (int i = 0; i < outQ.size() && i < expQ.size(); i++) begin
        nChecks++;
        if (outQ[i] !== expQ[i]) begin
          nFail++; $display("[TB] FAIL rand%0d beat %0d: got %h required %h", f, i, outQ[i], expQ[i]);
        end
      end
      nChecks += 2;
      if (goodCnt !== expGood) begin nFail++; $display("[TB] FAIL rand%0d good: got %0d required %0d", f, goodCnt, expGood); end
      if (badCnt !== expBad)   begin nFail++; $display("[TB] FAIL rand%0d bad: got %0d required %0d", f, badCnt, expBad); end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] hold;
    bit haveHold;
    hold = 8'h00;
    haveHold = 1'b0;
    build_frame(64, 1'b1, 1'b0);
    clear_obs();
    fork
      send_bytes(0, 64, 8);
      begin
        repeat (200) @(negedge clk);
        mReady = 1'b0;
        repeat (20) begin
          @(negedge clk); #1;
          if (mValid) begin
            if (haveHold) begin
              nChecks++;
              if (mData !== hold) begin nFail++; $display("[TB] FAIL ovf hold data: got %h required %h", mData, hold); end
            end else begin
              hold = mData; haveHold = 1'b1;
            end
          end
        end
        @(negedge clk); mReady = 1'b1;
      end
    join
    repeat (TO + 20) @(negedge clk);
    nChecks += 6;
    if (haveHold !== 1'b1)    begin nFail++; $display("[TB] FAIL ovf held beat: got %0d required 1", haveHold); end
    if ((ovfCnt > 0) !== 1'b1) begin nFail++; $display("[TB] FAIL ovf pulses: got %0d required >0", ovfCnt); end
    if (outQ.size() !== 60 - ovfCnt) begin nFail++; $display("[TB] FAIL ovf beats: got %0d required %0d", outQ.size(), 60 - ovfCnt); end
    if (goodCnt !== 0) begin nFail++; $display("[TB] FAIL ovf good: got %0d required 0", goodCnt); end
    if (badCnt !== 1)  begin nFail++; $display("[TB] FAIL ovf bad: got %0d required 1", badCnt); end
    if (outQ.size() == 0) begin nFail++; $display("[TB] FAIL ovf last beat: got none required %h", 10'h33B); end
    else if (outQ[outQ.size()-1] !== 10'h33B) begin
      nFail++; $display("[TB] FAIL ovf last beat: got %h required %h", outQ[outQ.size()-1], 10'h33B);
    end
  endtask

  task automatic test_reset_midframe();
    build_frame(64, 1'b1, 1'b0);
    send_bytes(0, 30, 8);
    rstN = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      nChecks++;
      if ({mValid, mData, mLast, mUser, frameGood, frameBad, overflow, sReady} !== {14'h0, 1'b1}) begin
        nFail++;
        $display("[TB] FAIL midreset outputs: got %h required %h",
                 {mValid, mData, mLast, mUser, frameGood, frameBad, overflow, sReady}, {14'h0, 1'b1});
      end
      repeat (3) @(negedge clk);
    end
    rstN = 1'b1;
    clear_obs();
    model_frame(0, 64);
    send_bytes(0, 64, 8);
    repeat (TO + 20) @(negedge clk);
    nChecks++;
    if (outQ.size() !== expQ.size()) begin
      nFail++; $display("[TB] FAIL midreset beats: got %0d required %0d", outQ.size(), expQ.size());
    end
    for (int i = 0; i < outQ.size() && i < expQ.size(); i++) begin
      nChecks++;
      if (outQ[i] !== expQ[i]) begin
        nFail++; $display("[TB] FAIL midreset beat %0d: got %h required %h", i, outQ[i], expQ[i]);
      end
    end
    nChecks += 3;
    if (goodCnt !== expGood) begin nFail++; $display("[TB] FAIL midreset good: got %0d required %0d", goodCnt, expGood); end
    if (badCnt !== expBad)   begin nFail++; $display("[TB] FAIL midreset bad: got %0d required %0d", badCnt, expBad); end
    if (ovfCnt !== 0)        begin nFail++; $display("[TB] FAIL midreset ovf: got %0d required 0", ovfCnt); end
  endtask

  initial begin
    test_reset();
    test_fcs();
    test_runt();
    test_idle_gap();
    test_random_frames();
    test_overflow();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
